uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver at the front of the command path: it recovers 8-bit bytes from the asynchronous `rx_i` line (8N1, LSB first) and presents each byte with a one-cycle strobe. `rx_data_o`/`rx_done_o` feed the register-command FSM's `data_i`/`rx_done_i` directly. Frame errors are reported separately and never produce a strobe on `rx_done_o`.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per bit (100 MHz / 115200); integer, minimum 4.
- `clk`  input  1  system clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `rx_i`  input  1  serial line, asynchronous to `clk`, idle high.
- `rx_data_o`  output  8  last correctly received byte.
- `rx_done_o`  output  1  one-cycle pulse: new valid byte on `rx_data_o`.
- `frame_err_o`  output  1  one-cycle pulse: stop bit sampled low.
- `parity_err_o`  output  1  one-cycle pulse: parity mismatch (see Configuration).
- `busy_o`  output  1  high while a frame is being received.

One clock domain; reset is asynchronous and active-low.

## Operation
- `rx_i` passes through a 2-flop synchroniser (both flops reset to 1). The output is `rx_s`. Only `rx_s` is used internally.
- `H = CLKS_PER_BIT/2` (floor). `baud_cnt` is sized to hold `CLKS_PER_BIT-1`. `bit_idx` is 3 bits.
- States:
  - S_IDLE: `rx_s==0` -> S_START, `baud_cnt=0`.
  - S_START:
    - Count up. At `baud_cnt==H-1`, sample `rx_s`.
    - If 0: -> S_DATA with `baud_cnt=0`, `bit_idx=0`.
    - If 1: glitch; -> S_IDLE, no pulse.
  - S_DATA:
    - Count up. At `baud_cnt==CLKS_PER_BIT-1`, shift `rx_s` into the MSB of the shift register (shift right, LSB received first). Then `baud_cnt=0`, `bit_idx++`.
    - After the sample with `bit_idx==7` -> S_STOP (or S_PARITY when enabled).
  - S_STOP: at `baud_cnt==CLKS_PER_BIT-1`, sample `rx_s`.
    - If 1: load `rx_data_o` from the shift register, pulse `rx_done_o`, -> S_IDLE.
    - If 0: pulse `frame_err_o`, leave `rx_data_o` unchanged, -> S_BREAK.
  - S_BREAK: wait for `rx_s==1`, then -> S_IDLE. A held-low line (break) yields exactly one `frame_err_o`.
- `busy_o = (state != S_IDLE)`, registered.
- All outputs are registered. `rx_data_o` holds its value until the next good frame.

## Timing
- Reset values:
  - `rx_data_o=0`
  - `rx_done_o=0`, `frame_err_o=0`, `parity_err_o=0`, `busy_o=0`
  - state S_IDLE, counters 0, synchroniser flops 1.
- Let edge t0 be the first `clk` edge that captures `rx_i` low into synchroniser flop 1.
  - S_START is entered at edge t0+2.
  - Data bit i is sampled at edge t0+2+H+(i+1)·N, where N=`CLKS_PER_BIT`.
  - Stop is sampled at edge t0+2+H+9N. `rx_done_o`/`frame_err_o` are high for the single cycle following that edge.
  - With parity enabled, add N.
- All sampling is mid-bit, referenced to the start-bit midpoint. Tolerates ±(H−2)/(10N) baud mismatch.
- Back-to-back frames: a start edge arriving in the first cycle of S_IDLE after a stop sample is accepted. No idle gap beyond one stop bit is required.
- Reset mid-frame: abort immediately and discard the partial byte. Outputs take reset values.
- A line held low across reset release is treated as a start bit and yields `frame_err_o` then S_BREAK.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds state S_PARITY after bit 7. It samples the even-parity bit at `baud_cnt==CLKS_PER_BIT-1`, then -> S_STOP.
  - At the stop sample, results are resolved as follows:
    - Stop low: `frame_err_o` only. Frame error takes precedence.
    - Stop high, parity mismatch: `parity_err_o` only. `rx_data_o` unchanged, no `rx_done_o`.
    - Stop high, parity ok: normal `rx_done_o`.
- Not defined: no S_PARITY, 10-bit 8N1 frame, `parity_err_o` tied 0.

## Test plan
Bench uses `CLKS_PER_BIT=8`.
- Frame 0xA5 -> `rx_done_o` for exactly one cycle after edge t0+78; `rx_data_o=0xA5`; `busy_o` low the following cycle.
- Frames 0x01, 0x10, 0x5A sent back-to-back (single stop bits) -> three `rx_done_o` pulses spaced 80 cycles apart, data 0x01/0x10/0x5A; no `frame_err_o`.
- `rx_i` low for 2 cycles then high -> no pulse of any kind; `busy_o` returns to 0 within H+3 cycles.
- Frame 0x3C with stop bit low and line held low for 20 bit times -> exactly one `frame_err_o` pulse; `rx_data_o` keeps its previous value. Next frame 0x55 after the line returns high -> `rx_done_o`, `rx_data_o=0x55`.
- `rst_n` asserted during data bit 4 of 0xFF -> all outputs 0 at once. Frame 0x7E after release -> received correctly.
- With `UART_RX_PARITY_EN`:
  - 0x07 with parity bit 1 -> `rx_done_o`, data 0x07.
  - 0x07 with parity bit 0 -> `parity_err_o` pulse, `rx_data_o` unchanged.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling referenced to the start-bit midpoint.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN (adds a parity bit
// between data bit 7 and the stop bit); without it parity_err_o is tied low.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_done_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       busy_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HalfM1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BitEnd = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  state_e        state_q, state_d;
  logic          sync1_q, rx_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          busy_q;

  // Two-flop synchroniser; idle-high reset value so reset release is not seen as a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      rx_s    <= sync1_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;

  // Parity bit capture and parity error pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

  // Receiver state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  // Next-state logic: frame sequencing, bit sampling and result pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfM1) begin
          cnt_d = '0;
          idx_d = '0;
          // A start bit that is gone by its midpoint was a glitch.
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StData: begin
        if (cnt_q == BitEnd) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StParity: begin
        if (cnt_q == BitEnd) begin
          cnt_d   = '0;
          state_d = StStop;
`ifdef UART_RX_PARITY_EN
          par_d = rx_s;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StStop: begin
        if (cnt_q == BitEnd) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            if ((^shift_q) != par_q) begin
              perr_d = 1'b1;
            end else begin
              data_d = shift_q;
              done_d = 1'b1;
            end
`else
            data_d = shift_q;
            done_d = 1'b1;
`endif
          end else begin
            // Frame error wins over parity; wait out a break before re-arming.
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StBreak: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rx_data_o   = data_q;
  assign rx_done_o   = done_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with CLKS_PER_BIT = 8; define UART_RX_PARITY_EN to cover parity.
module tb_uart_rx;

  localparam int unsigned N = 8;
  localparam int unsigned H = N / 2;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned FrameBits = 11;
`else
  localparam int unsigned FrameBits = 10;
`endif
  // Edges from t0 to the stop sample.
  localparam int unsigned StopLat = 2 + H + (FrameBits - 1) * N;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_i = 1'b1;
  logic [7:0] rx_data_o;
  logic       rx_done_o;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int done_cyc[$];
  logic [7:0] done_dat[$];

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .rx_data_o   (rx_data_o),
    .rx_done_o   (rx_done_o),
    .frame_err_o (frame_err_o),
    .parity_err_o(parity_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_done_o) begin
        done_cnt++;
        done_cyc.push_back(cyc);
        done_dat.push_back(rx_data_o);
      end
      if (frame_err_o) ferr_cnt++;
      if (parity_err_o) perr_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    done_cnt = 0;
    ferr_cnt = 0;
    perr_cnt = 0;
    done_cyc.delete();
    done_dat.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 exactly one frame later, line left at stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    rx_i = 1'b0;
    t0 = cyc + 1;
    wait_cycles(N);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_cycles(N);
    end
`ifdef UART_RX_PARITY_EN
    rx_i = par;
    wait_cycles(N);
`endif
    rx_i = stop;
    wait_cycles(N);
  endtask

  initial begin
    int first_t0;
    #2;
    check_eq("reset_data", rx_data_o, 8'h00);
    check_eq("reset_done", rx_done_o, 1'b0);
    check_eq("reset_ferr", frame_err_o, 1'b0);
    check_eq("reset_perr", parity_err_o, 1'b0);
    check_eq("reset_busy", busy_o, 1'b0);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(4);

    // Single frame, latency check.
    clear_mon();
    send_frame(8'hA5, 1'b1, ^8'hA5);
    wait_cycles(2);
    check_eq("a5_count", done_cnt, 1);
    if (done_cyc.size() > 0) check_eq("a5_latency", done_cyc[0] - t0, StopLat);
    check_eq("a5_data", rx_data_o, 8'hA5);
    check_eq("a5_busy_after", busy_o, 1'b0);

    // Back-to-back frames with single stop bits.
    clear_mon();
    send_frame(8'h01, 1'b1, ^8'h01);
    first_t0 = t0;
    send_frame(8'h10, 1'b1, ^8'h10);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    wait_cycles(2);
    check_eq("b2b_count", done_cnt, 3);
    check_eq("b2b_ferr", ferr_cnt, 0);
    if (done_cyc.size() == 3) begin
      check_eq("b2b_lat0", done_cyc[0] - first_t0, StopLat);
      check_eq("b2b_gap0", done_cyc[1] - done_cyc[0], FrameBits * N);
      check_eq("b2b_gap1", done_cyc[2] - done_cyc[1], FrameBits * N);
      check_eq("b2b_d0", done_dat[0], 8'h01);
      check_eq("b2b_d1", done_dat[1], 8'h10);
      check_eq("b2b_d2", done_dat[2], 8'h5A);
    end

    // Two-cycle glitch.
    clear_mon();
    rx_i = 1'b0;
    wait_cycles(2);
    rx_i = 1'b1;
    wait_cycles(3);
    check_eq("glitch_busy_mid", busy_o, 1'b1);
    wait_cycles(H + 3);
    check_eq("glitch_busy_end", busy_o, 1'b0);
    check_eq("glitch_pulses", done_cnt + ferr_cnt + perr_cnt, 0);

    // Stop bit low followed by a long break.
    clear_mon();
    send_frame(8'h3C, 1'b0, ^8'h3C);
    wait_cycles(20 * N);
    check_eq("break_busy", busy_o, 1'b1);
    rx_i = 1'b1;
    wait_cycles(2 * N);
    check_eq("break_ferr", ferr_cnt, 1);
    check_eq("break_done", done_cnt, 0);
    check_eq("break_data", rx_data_o, 8'h5A);
    check_eq("break_busy_end", busy_o, 1'b0);
    clear_mon();
    send_frame(8'h55, 1'b1, ^8'h55);
    wait_cycles(2);
    check_eq("after_break_count", done_cnt, 1);
    check_eq("after_break_data", rx_data_o, 8'h55);

    // Reset during data bit 4 of 0xFF.
    rx_i = 1'b0;
    wait_cycles(N);
    rx_i = 1'b1;
    wait_cycles(4 * N + H);
    check_eq("pre_rst_busy", busy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_data", rx_data_o, 8'h00);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_done", rx_done_o, 1'b0);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(4);
    clear_mon();
    send_frame(8'h7E, 1'b1, ^8'h7E);
    wait_cycles(2);
    check_eq("post_rst_count", done_cnt, 1);
    check_eq("post_rst_data", rx_data_o, 8'h7E);
    check_eq("post_rst_ferr", ferr_cnt, 0);

`ifdef UART_RX_PARITY_EN
    // Wrong parity first, so the unchanged data is distinguishable.
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0);
    wait_cycles(2);
    check_eq("par_bad_perr", perr_cnt, 1);
    check_eq("par_bad_done", done_cnt, 0);
    check_eq("par_bad_data", rx_data_o, 8'h7E);
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1);
    wait_cycles(2);
    check_eq("par_ok_done", done_cnt, 1);
    check_eq("par_ok_perr", perr_cnt, 0);
    check_eq("par_ok_data", rx_data_o, 8'h07);
`else
    check_eq("perr_tied", perr_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
